// File: rtl/file_arbiter_pkg.sv
// file_ctrl_pkg: shared constants for the register-file arbiter.
//   OP_READ / OP_WRITE : operation codes understood by the 16x8 file;
//                        every other code is a pass-through (ac -> file_out).
//   state_t            : sequencer state encoding (IDLE, ISSUE, CAPTURE).
package file_ctrl_pkg;

   localparam logic [3:0] OP_READ  = 4'b0000;
   localparam logic [3:0] OP_WRITE = 4'b0001;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   // Writes finish after ISSUE; everything else needs a CAPTURE cycle.
   function automatic logic is_write(input logic [3:0] op);
      return op == OP_WRITE;
   endfunction

endpackage

// File: rtl/file_arbiter_if.sv
// file_arbiter_if: one requester's handshake with the arbiter.
//   req    requester -> arbiter  request, held until ack
//   op     requester -> arbiter  operation code
//   addr   requester -> arbiter  file address
//   wdata  requester -> arbiter  write / pass-through data
//   ack    arbiter -> requester  one-cycle accept pulse
//   rdata  arbiter -> requester  returned data, held until the next read
//   rvalid arbiter -> requester  one-cycle pulse, rdata valid
// master = requester side, slave = arbiter side.
interface file_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              req;
   logic [3:0]        op;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (output req, op, addr, wdata, input ack, rdata, rvalid);
   modport slave  (input req, op, addr, wdata, output ack, rdata, rvalid);
endinterface

// File: rtl/file_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant.
//   clk, rst  clock / asynchronous active-low reset
//   req_a/b   request lines
//   accept    strobe: the current grant was taken, remember it
//   grant_a/b combinational one-hot (or zero) grant
// After reset the last grant is B, so A wins the first tie.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic accept,
   output logic grant_a,
   output logic grant_b
);
   logic last_b;

   always_comb begin
      grant_a = req_a && (!req_b || last_b);
      grant_b = req_b && !grant_a;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_b <= 1'b1;
      end else if (accept) begin
         last_b <= grant_b;
      end
   end
endmodule

// File: rtl/file_arbiter.sv
// file_arbiter: two-requester round-robin arbiter/sequencer for the 16x8
// register file. A is the control unit, B the debug/loader port.
//   clk, rst          clock / asynchronous active-low reset
//   port_a, port_b    requester handshakes (file_arbiter_if.slave)
//   file_en           one-cycle file enable
//   operation/addr/ac file command, held when file_en is low
//   file_out          registered file output, captured for non-write ops
//   busy              high whenever the sequencer is not IDLE
//   err               one-cycle pulse on a rejected (out-of-range) request
// Optional feature macro FILE_ADDR_CHECK_EN: when defined, a winning request
// with addr >= DEPTH is acked with err and never reaches the file. When
// undefined, err is tied low and every address is forwarded unchanged.
module file_arbiter
   import file_ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   file_arbiter_if.slave     port_a,
   file_arbiter_if.slave     port_b,
   output logic              file_en,
   output logic [3:0]        operation,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] ac,
   input  logic [DATA_W-1:0] file_out,
   output logic              busy,
   output logic              err
);
   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic              file_en_q, file_en_d;
   logic [3:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] ac_q, ac_d;
   logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
   logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
   logic              owner_b_q, owner_b_d;

   logic              grant_a, grant_b, accept;
   logic [3:0]        win_op;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              win_in_range;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_a   (port_a.req),
      .req_b   (port_b.req),
      .accept  (accept),
      .grant_a (grant_a),
      .grant_b (grant_b)
   );

   always_comb begin
      win_op    = port_b.op;
      win_addr  = port_b.addr;
      win_wdata = port_b.wdata;
      if (grant_a) begin
         win_op    = port_a.op;
         win_addr  = port_a.addr;
         win_wdata = port_a.wdata;
      end
   end

   assign win_in_range = ({1'b0, win_addr} < DEPTH_L);

`ifdef FILE_ADDR_CHECK_EN
   logic err_q, err_d;
`else
   logic range_unused;
   assign range_unused = win_in_range;
`endif

   always_comb begin
      state_d    = state_q;
      file_en_d  = 1'b0;
      op_d       = op_q;
      addr_d     = addr_q;
      ac_d       = ac_q;
      ack_a_d    = 1'b0;
      ack_b_d    = 1'b0;
      rvalid_a_d = 1'b0;
      rvalid_b_d = 1'b0;
      rdata_a_d  = rdata_a_q;
      rdata_b_d  = rdata_b_q;
      owner_b_d  = owner_b_q;
      accept     = 1'b0;
`ifdef FILE_ADDR_CHECK_EN
      err_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (grant_a || grant_b) begin
               accept    = 1'b1;
               owner_b_d = grant_b;
               ack_a_d   = grant_a;
               ack_b_d   = grant_b;
`ifdef FILE_ADDR_CHECK_EN
               // Rejected requests are acked but leave the file command alone.
               if (!win_in_range) begin
                  err_d = 1'b1;
               end else begin
                  op_d      = win_op;
                  addr_d    = win_addr;
                  ac_d      = win_wdata;
                  file_en_d = 1'b1;
                  state_d   = ISSUE;
               end
`else
               op_d      = win_op;
               addr_d    = win_addr;
               ac_d      = win_wdata;
               file_en_d = 1'b1;
               state_d   = ISSUE;
`endif
            end
         end
         ISSUE: begin
            state_d = is_write(op_q) ? IDLE : CAPTURE;
         end
         CAPTURE: begin
            if (owner_b_q) begin
               rdata_b_d  = file_out;
               rvalid_b_d = 1'b1;
            end else begin
               rdata_a_d  = file_out;
               rvalid_a_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         file_en_q  <= 1'b0;
         op_q       <= '0;
         addr_q     <= '0;
         ac_q       <= '0;
         ack_a_q    <= 1'b0;
         ack_b_q    <= 1'b0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
         owner_b_q  <= 1'b0;
`ifdef FILE_ADDR_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         file_en_q  <= file_en_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         ac_q       <= ac_d;
         ack_a_q    <= ack_a_d;
         ack_b_q    <= ack_b_d;
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
         rdata_a_q  <= rdata_a_d;
         rdata_b_q  <= rdata_b_d;
         owner_b_q  <= owner_b_d;
`ifdef FILE_ADDR_CHECK_EN
         err_q      <= err_d;
`endif
      end
   end

`ifdef FILE_ADDR_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign file_en       = file_en_q;
   assign operation     = op_q;
   assign addr          = addr_q;
   assign ac            = ac_q;
   assign busy          = (state_q != IDLE);
   assign port_a.ack    = ack_a_q;
   assign port_a.rdata  = rdata_a_q;
   assign port_a.rvalid = rvalid_a_q;
   assign port_b.ack    = ack_b_q;
   assign port_b.rdata  = rdata_b_q;
   assign port_b.rvalid = rvalid_b_q;

endmodule

// File: doc/file_arbiter.md
Name: file_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 16x8 register file.
- Requester A is the core control unit; requester B is the debug/loader port.
- Accepts one request at a time and drives the file's file_en/operation/addr/ac inputs for exactly one cycle.
- Captures file_out for read-type operations and returns it to the granted requester with a valid pulse.

Parameters:
- DATA_W, 8, data width of ac/file_out/wdata/rdata
- ADDR_W, 8, address width presented to the file
- DEPTH, 16, number of implemented file entries (used only by the optional check)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- req_a  in  1  request from A; held until ack_a
- op_a  in  4  operation for A (0000 read, 0001 write, other = pass-through)
- addr_a  in  ADDR_W  address for A
- wdata_a  in  DATA_W  write/pass-through data for A
- ack_a  out  1  one-cycle pulse: A's request accepted
- rdata_a  out  DATA_W  returned data for A
- rvalid_a  out  1  one-cycle pulse: rdata_a valid
- req_b, op_b, addr_b, wdata_b, ack_b, rdata_b, rvalid_b  same as A, for B
- file_en  out  1  file enable
- operation  out  4  file operation
- addr  out  ADDR_W  file address
- ac  out  DATA_W  file write/pass-through data
- file_out  in  DATA_W  registered file output
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse on a rejected request (only with the optional feature)

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all outputs 0; grant pointer = B, so A wins the first tie. An in-flight operation is abandoned; file contents are untouched.
- States: IDLE, ISSUE, CAPTURE. All outputs are registered.
- IDLE at edge E0:
  - If any req is high, select a winner: a single requester wins outright; if both are high, grant the one not granted last.
  - Load operation/addr/ac from the winner, set file_en=1 and the winner's ack=1, update the grant pointer, go to ISSUE.
  - If no req is high, hold all outputs at 0.
- ISSUE at edge E1: the file samples its inputs on this edge.
  - Clear file_en and ack.
  - If op=0001 (write), go to IDLE.
  - Otherwise go to CAPTURE.
- CAPTURE at edge E2: rdata_x <= file_out, rvalid_x=1 for one cycle for the granted requester, go to IDLE.
- rdata_x holds its value until the next read completes for that requester.
- Latency from req sampled to effect:
  - write: ack in cycle E0..E1; file updated at E1; next acceptance possible at E2 (2 cycles/op).
  - read or pass-through: ack in cycle E0..E1; rvalid in cycle E2..E3; next acceptance possible at E3 (3 cycles/op).
- Handshake: the requester must hold op/addr/wdata stable while req is high and unacked. It must deassert req, or present a new request, during its ack cycle. A req still high at the next IDLE sample is a new request.
- Outputs operation/addr/ac hold their last values when file_en=0.
- No starvation: with both requesters continuously requesting, grants alternate A,B,A,B.
- A req arriving while busy waits; nothing is queued internally.

Optional Feature:
- Macro: FILE_ADDR_CHECK_EN.
- Defined: in IDLE, a winning request with addr >= DEPTH is rejected.
  - file_en stays 0; ack_x=1 and err=1 pulse for one cycle.
  - State stays IDLE; the grant pointer advances as normal.
  - rvalid is never asserted for a rejected request.
- Undefined: err is tied to 0 and every address is forwarded unchanged.

Decomposition:
- Package file_ctrl_pkg holds: OP_READ=4'b0000, OP_WRITE=4'b0001, and the state encoding (IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2).
- One sub-module, rr_arb2: 2-input round-robin grant with a last-grant register, advanced by an accept strobe.

Test Plan:
- Reset values: assert rst low mid-CAPTURE -> all outputs 0 immediately, busy=0; after release, a simultaneous req_a/req_b -> A granted first.
- Write then read: A writes 8'hA5 to addr 3 -> file_en for one cycle with operation=0001, addr=3, ac=A5. A then reads addr 3 -> rvalid_a 2 cycles after ack_a with rdata_a=A5.
- Round-robin: A and B both continuously read addr 5 and addr 9 (initial contents) -> grants alternate A,B,A,B; rdata_a=05, rdata_b=09; a new grant every 3 cycles.
- Pass-through: B issues op=0111 with wdata=8'h3C -> rdata_b=3C, rvalid_b pulses once, file contents unchanged (a subsequent read of addr 12 returns 0C).
- Hold-off: req_b raised while busy with A's read -> ack_b no earlier than the cycle after rvalid_a; exactly one file_en per request.
- With FILE_ADDR_CHECK_EN defined: A reads addr 8'h20 -> ack_a and err pulse together, file_en stays 0, no rvalid_a. Without the macro: the same stimulus gives file_en=1 and err=0.
